icache_tag_req_arb: RTL and testbench

- Three-source arbiter in front of the icache tag array controller; owns its tag_req_vld / tagram_req_rdy / tag_req_pld handshake.
- Requesters: instruction fetch (upstream), prefetcher, downstream snoop.
- Each source has a one-entry holding buffer. Fixed priority with prefetch anti-starvation aging; flush support.

---
 rtl/toy_pack.sv | 35 +++
 rtl/icache_req_skid_buf.sv | 49 ++++
 rtl/icache_tag_req_arb.sv | 119 +++++++++++
 tb/tb_icache_tag_req_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// Shared icache request types, opcodes and arbiter source indices.
package toy_pack;

    localparam int PF_STARVE_LIMIT_DEFAULT = 8;

    typedef logic [1:0] opcode_t;

    localparam opcode_t UPSTREAM_OPCODE   = 2'd1;
    localparam opcode_t PREFETCH_OPCODE   = 2'd2;
    localparam opcode_t DOWNSTREAM_OPCODE = 2'd3;

    typedef struct packed {
        logic [19:0] tag;
        logic [5:0]  index;
        logic [5:0]  offset;
    } pc_addr_t;

    typedef struct packed {
        opcode_t     opcode;
        pc_addr_t    addr;
        logic [7:0]  txn_id;
    } pc_req_t;

    typedef enum logic [1:0] {
        SRC_PF    = 2'd0,
        SRC_FETCH = 2'd1,
        SRC_SNP   = 2'd2
    } src_idx_e;

    // Cache-line identity: offset bits are ignored.
    function automatic logic [25:0] line_of(input pc_addr_t a);
        return {a.tag, a.index};
    endfunction

endpackage

// File: rtl/icache_req_skid_buf.sv
// One-entry vld/rdy holding buffer that stamps its source opcode on enqueue.
module icache_req_skid_buf
    import toy_pack::*;
#(
    parameter opcode_t STAMP_OPCODE = UPSTREAM_OPCODE
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_vld,
    output logic    o_rdy,
    input  pc_req_t i_pld,
    input  logic    i_flush,
    input  logic    i_drop,
    input  logic    i_deq,
    output logic    o_vld,
    output pc_req_t o_pld
);

    logic    r_vld;
    pc_req_t r_pld;
    logic    w_enq;
    pc_req_t w_stamped;

    // Accepting while being dequeued keeps full throughput; dropped or flushed
    // requests still handshake but never land in the buffer.
    assign o_rdy = !rst && (!r_vld || i_deq);
    assign w_enq = i_vld && o_rdy && !i_drop && !i_flush;

    always_comb begin
        w_stamped        = i_pld;
        w_stamped.opcode = STAMP_OPCODE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_pld <= '0;
        end else if (w_enq) begin
            r_vld <= 1'b1;
            r_pld <= w_stamped;
        end else if (i_deq || i_flush) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_pld = r_pld;

endmodule

// File: rtl/icache_tag_req_arb.sv
// Snoop/fetch/prefetch arbiter for the icache tag controller with prefetch aging.
// Optional ICACHE_PF_DEDUP_EN drops prefetches that hit a pending or recent fetch line.
module icache_tag_req_arb
    import toy_pack::*;
#(
    parameter int PF_STARVE_LIMIT = PF_STARVE_LIMIT_DEFAULT,
    parameter int AGE_W           = $clog2(PF_STARVE_LIMIT + 1)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    fetch_req_vld,
    output logic    fetch_req_rdy,
    input  pc_req_t fetch_req_pld,
    input  logic    pf_req_vld,
    output logic    pf_req_rdy,
    input  pc_req_t pf_req_pld,
    input  logic    snp_req_vld,
    output logic    snp_req_rdy,
    input  pc_req_t snp_req_pld,
    input  logic    flush,
    output logic    tag_req_vld,
    input  logic    tagram_req_rdy,
    output pc_req_t tag_req_pld,
    output logic [2:0] grant_src
);

    logic [2:0]       w_vld;
    logic [2:0]       w_sel;
    pc_req_t          w_pf_pld;
    pc_req_t          w_fetch_pld;
    pc_req_t          w_snp_pld;
    logic             w_pf_drop;
    logic             w_promote;
    logic [AGE_W-1:0] r_age;

    icache_req_skid_buf #(.STAMP_OPCODE(PREFETCH_OPCODE)) u_pf_buf (
        .clk(clk), .rst(rst),
        .i_vld(pf_req_vld), .o_rdy(pf_req_rdy), .i_pld(pf_req_pld),
        .i_flush(flush), .i_drop(w_pf_drop), .i_deq(grant_src[SRC_PF]),
        .o_vld(w_vld[SRC_PF]), .o_pld(w_pf_pld)
    );

    icache_req_skid_buf #(.STAMP_OPCODE(UPSTREAM_OPCODE)) u_fetch_buf (
        .clk(clk), .rst(rst),
        .i_vld(fetch_req_vld), .o_rdy(fetch_req_rdy), .i_pld(fetch_req_pld),
        .i_flush(flush), .i_drop(1'b0), .i_deq(grant_src[SRC_FETCH]),
        .o_vld(w_vld[SRC_FETCH]), .o_pld(w_fetch_pld)
    );

    icache_req_skid_buf #(.STAMP_OPCODE(DOWNSTREAM_OPCODE)) u_snp_buf (
        .clk(clk), .rst(rst),
        .i_vld(snp_req_vld), .o_rdy(snp_req_rdy), .i_pld(snp_req_pld),
        .i_flush(1'b0), .i_drop(1'b0), .i_deq(grant_src[SRC_SNP]),
        .o_vld(w_vld[SRC_SNP]), .o_pld(w_snp_pld)
    );

`ifdef ICACHE_PF_DEDUP_EN
    logic        r_last_vld;
    logic [25:0] r_last_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_vld  <= 1'b0;
            r_last_line <= '0;
        end else if (flush) begin
            r_last_vld  <= 1'b0;
        end else if (grant_src[SRC_FETCH]) begin
            r_last_vld  <= 1'b1;
            r_last_line <= line_of(w_fetch_pld.addr);
        end
    end

    assign w_pf_drop = (w_vld[SRC_FETCH] && (line_of(pf_req_pld.addr) == line_of(w_fetch_pld.addr)))
                    || (r_last_vld && (line_of(pf_req_pld.addr) == r_last_line));
`else
    assign w_pf_drop = 1'b0;
`endif

    assign w_promote = (r_age == AGE_W'(PF_STARVE_LIMIT));

    // A promoted prefetch wins exactly one grant; the age then clears.
    always_comb begin
        w_sel = '0;
        if (w_promote && w_vld[SRC_PF]) begin
            w_sel[SRC_PF] = 1'b1;
        end else if (w_vld[SRC_SNP]) begin
            w_sel[SRC_SNP] = 1'b1;
        end else if (w_vld[SRC_FETCH]) begin
            w_sel[SRC_FETCH] = 1'b1;
        end else if (w_vld[SRC_PF]) begin
            w_sel[SRC_PF] = 1'b1;
        end
    end

    always_comb begin
        tag_req_pld = '0;
        if (w_sel[SRC_SNP]) begin
            tag_req_pld = w_snp_pld;
        end else if (w_sel[SRC_FETCH]) begin
            tag_req_pld = w_fetch_pld;
        end else if (w_sel[SRC_PF]) begin
            tag_req_pld = w_pf_pld;
        end
    end

    assign tag_req_vld = |w_vld;
    assign grant_src   = tagram_req_rdy ? w_sel : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (flush || !w_vld[SRC_PF] || grant_src[SRC_PF]) begin
            r_age <= '0;
        end else if (tagram_req_rdy && !w_promote) begin
            r_age <= r_age + 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_tag_req_arb.sv
// Scoreboard bench for icache_tag_req_arb: directed stimulus pushes expected grants,
// a negedge monitor pops and compares every handshaken grant.
module tb_icache_tag_req_arb;
    import toy_pack::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch_req_vld = 1'b0;
    logic       fetch_req_rdy;
    pc_req_t    fetch_req_pld = '0;
    logic       pf_req_vld = 1'b0;
    logic       pf_req_rdy;
    pc_req_t    pf_req_pld = '0;
    logic       snp_req_vld = 1'b0;
    logic       snp_req_rdy;
    pc_req_t    snp_req_pld = '0;
    logic       flush = 1'b0;
    logic       tag_req_vld;
    logic       tagram_req_rdy = 1'b0;
    pc_req_t    tag_req_pld;
    logic [2:0] grant_src;

    typedef struct packed {
        logic [2:0] src;
        pc_req_t    pld;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    icache_tag_req_arb #(.PF_STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_vld(fetch_req_vld), .fetch_req_rdy(fetch_req_rdy), .fetch_req_pld(fetch_req_pld),
        .pf_req_vld(pf_req_vld), .pf_req_rdy(pf_req_rdy), .pf_req_pld(pf_req_pld),
        .snp_req_vld(snp_req_vld), .snp_req_rdy(snp_req_rdy), .snp_req_pld(snp_req_pld),
        .flush(flush),
        .tag_req_vld(tag_req_vld), .tagram_req_rdy(tagram_req_rdy), .tag_req_pld(tag_req_pld),
        .grant_src(grant_src)
    );

    always #5 clk = ~clk;

    function automatic pc_req_t mkReq(input logic [19:0] tag, input logic [5:0] idx,
                                      input logic [5:0] off, input logic [7:0] id);
        pc_req_t r;
        r             = '0;
        r.opcode      = 2'd0;
        r.addr.tag    = tag;
        r.addr.index  = idx;
        r.addr.offset = off;
        r.txn_id      = id;
        return r;
    endfunction

    function automatic pc_req_t stampReq(input pc_req_t r, input opcode_t op);
        pc_req_t s;
        s        = r;
        s.opcode = op;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fv, input pc_req_t fp, input logic pv, input pc_req_t pp,
                                 input logic sv, input pc_req_t sp, input logic rdy, input logic fl);
        fetch_req_vld  = fv;
        fetch_req_pld  = fp;
        pf_req_vld     = pv;
        pf_req_pld     = pp;
        snp_req_vld    = sv;
        snp_req_pld    = sp;
        tagram_req_rdy = rdy;
        flush          = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [2:0] src, input pc_req_t pld);
        exp_t e;
        e.src = src;
        e.pld = pld;
        expQ.push_back(e);
    endtask

    // Monitor: every handshaken grant must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && tag_req_vld && tagram_req_rdy) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_grant: got src %0b pld %0h expected none", grant_src, tag_req_pld);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grant_src", 64'(grant_src), 64'(e.src));
                    checkOutput("grant_pld", 64'(tag_req_pld), 64'(e.pld));
                end
            end
        end
    end

    pc_req_t fReq, pReq, sReq;
    pc_req_t fSeq[5];
    pc_req_t zero = '0;

    initial begin
        // Reset state
        #2;
        checkOutput("rst_tag_req_vld", 64'(tag_req_vld), 64'd0);
        checkOutput("rst_grant_src", 64'(grant_src), 64'd0);
        checkOutput("rst_tag_req_pld", 64'(tag_req_pld), 64'd0);
        checkOutput("rst_rdys", 64'({fetch_req_rdy, pf_req_rdy, snp_req_rdy}), 64'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_rdys", 64'({fetch_req_rdy, pf_req_rdy, snp_req_rdy}), 64'b111);
        nextCycle();

        // All three sources at once: snoop, fetch, prefetch in that order
        fReq = mkReq(20'h00101, 6'd1, 6'd0, 8'h11);
        pReq = mkReq(20'h00202, 6'd2, 6'd4, 8'h22);
        sReq = mkReq(20'h00303, 6'd3, 6'd8, 8'h33);
        applyStimulus(1'b1, fReq, 1'b1, pReq, 1'b1, sReq, 1'b1, 1'b0);
        pushExp(3'b100, stampReq(sReq, DOWNSTREAM_OPCODE));
        pushExp(3'b010, stampReq(fReq, UPSTREAM_OPCODE));
        pushExp(3'b001, stampReq(pReq, PREFETCH_OPCODE));
        nextCycle();
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b1, 1'b0);
        repeat (4) nextCycle();

        // Prefetch starvation: four fetch grants, then the promoted prefetch
        pReq = mkReq(20'h00404, 6'd4, 6'd0, 8'h40);
        for (int k = 0; k < 5; k++) begin
            fSeq[k] = mkReq(20'h00500 + 20'(k), 6'(10 + k), 6'd0, 8'(8'h50 + k));
        end
        for (int k = 0; k < 4; k++) pushExp(3'b010, stampReq(fSeq[k], UPSTREAM_OPCODE));
        pushExp(3'b001, stampReq(pReq, PREFETCH_OPCODE));
        pushExp(3'b010, stampReq(fSeq[4], UPSTREAM_OPCODE));
        applyStimulus(1'b1, fSeq[0], 1'b1, pReq, 1'b0, zero, 1'b1, 1'b0);
        for (int k = 1; k < 5; k++) begin
            nextCycle();
            applyStimulus(1'b1, fSeq[k], 1'b0, zero, 1'b0, zero, 1'b1, 1'b0);
        end
        nextCycle();
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b1, 1'b0);
        repeat (4) nextCycle();

        // Backpressure: fetch held stable for three cycles, then granted
        fReq = mkReq(20'h00606, 6'd6, 6'd2, 8'h66);
        applyStimulus(1'b1, fReq, 1'b0, zero, 1'b0, zero, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_tag_req_vld", 64'(tag_req_vld), 64'd1);
            checkOutput("bp_tag_req_pld", 64'(tag_req_pld), 64'(stampReq(fReq, UPSTREAM_OPCODE)));
            checkOutput("bp_fetch_rdy", 64'(fetch_req_rdy), 64'd0);
            checkOutput("bp_grant_src", 64'(grant_src), 64'd0);
            nextCycle();
        end
        pushExp(3'b010, stampReq(fReq, UPSTREAM_OPCODE));
        tagram_req_rdy = 1'b1;
        repeat (2) nextCycle();

        // Flush while all three are buffered: only snoop survives
        fReq = mkReq(20'h00707, 6'd7, 6'd0, 8'h70);
        pReq = mkReq(20'h00808, 6'd8, 6'd0, 8'h80);
        sReq = mkReq(20'h00909, 6'd9, 6'd0, 8'h90);
        applyStimulus(1'b1, fReq, 1'b1, pReq, 1'b1, sReq, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b0, 1'b1);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("fl_tag_req_vld", 64'(tag_req_vld), 64'd1);
        checkOutput("fl_tag_req_pld", 64'(tag_req_pld), 64'(stampReq(sReq, DOWNSTREAM_OPCODE)));
        checkOutput("fl_opcode", 64'(tag_req_pld.opcode), 64'(DOWNSTREAM_OPCODE));
        checkOutput("fl_fetch_pf_rdy", 64'({fetch_req_rdy, pf_req_rdy}), 64'b11);
        nextCycle();
        pushExp(3'b100, stampReq(sReq, DOWNSTREAM_OPCODE));
        tagram_req_rdy = 1'b1;
        repeat (3) nextCycle();

        // Prefetch to the line of a buffered fetch
        fReq = mkReq(20'h00012, 6'd5, 6'd0, 8'hA0);
        pReq = mkReq(20'h00012, 6'd5, 6'd16, 8'hA1);
        applyStimulus(1'b1, fReq, 1'b0, zero, 1'b0, zero, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, zero, 1'b1, pReq, 1'b0, zero, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("dd_pf_rdy", 64'(pf_req_rdy), 64'd1);
        nextCycle();
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b1, 1'b0);
        pushExp(3'b010, stampReq(fReq, UPSTREAM_OPCODE));
`ifndef ICACHE_PF_DEDUP_EN
        pushExp(3'b001, stampReq(pReq, PREFETCH_OPCODE));
`endif
        repeat (4) nextCycle();

        // Reset mid-operation with two buffers holding requests
        fReq = mkReq(20'h00B0B, 6'd11, 6'd0, 8'hB0);
        sReq = mkReq(20'h00C0C, 6'd12, 6'd0, 8'hC0);
        applyStimulus(1'b1, fReq, 1'b0, zero, 1'b1, sReq, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_tag_req_vld", 64'(tag_req_vld), 64'd1);
        #2;
        rst = 1'b1;
        tagram_req_rdy = 1'b1;
        #1;
        checkOutput("mid_rst_tag_req_vld", 64'(tag_req_vld), 64'd0);
        checkOutput("mid_rst_grant_src", 64'(grant_src), 64'd0);
        checkOutput("mid_rst_tag_req_pld", 64'(tag_req_pld), 64'd0);
        checkOutput("mid_rst_rdys", 64'({fetch_req_rdy, pf_req_rdy, snp_req_rdy}), 64'd0);
        fetch_req_vld = 1'b1;
        fetch_req_pld = fReq;
        repeat (2) nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, zero, 1'b0, zero, 1'b0, zero, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rel_rst_rdys", 64'({fetch_req_rdy, pf_req_rdy, snp_req_rdy}), 64'b111);
        checkOutput("rel_rst_tag_req_vld", 64'(tag_req_vld), 64'd0);
        repeat (4) nextCycle();

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
